// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: widths and the writeback entry format
// carried from the ALU result mux to the register-file writeback port.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int NUM_FN     = 16;
    localparam int FN_SEL_W   = 5;
    localparam int REG_ADDR_W = 4;

    // One writeback entry: the result plus everything decided at capture time.
    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [FN_SEL_W-1:0]   fn_sel;
        logic                  we;
        logic                  zero;
        logic                  neg;
        logic                  parity;
        logic                  illegal;
    } wb_entry_t;

    // A function select beyond the implemented set names no ALU function.
    function automatic logic fn_is_illegal(input logic [FN_SEL_W-1:0] fn);
        return (fn >= FN_SEL_W'(NUM_FN));
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry skid buffer for writeback entries. The main register drives the
// output; the skid register catches the one entry that can arrive while the
// output is stalled. in_ready depends only on skid occupancy, so there is no
// combinational path from out_ready back to in_ready.
module wb_skid_buf
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    output logic      in_ready,
    input  wb_entry_t in_entry,
    output logic      out_valid,
    input  logic      out_ready,
    output wb_entry_t out_entry
);

    wb_entry_t main_q;
    wb_entry_t skid_q;
    logic      main_valid;
    logic      skid_valid;
    logic      accept;
    logic      xfer;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign xfer      = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_entry = main_q;

    // Main/skid occupancy and data movement; strict FIFO order between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            // Skid is always empty when main is empty.
            if (accept) begin
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end
        end else if (xfer) begin
            if (skid_valid) begin
                // in_ready was low, so no new entry competes with the drain.
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q <= in_entry;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_wb_stage.sv
// ALU result writeback stage: captures the selected function result, derives
// status flags and the write-enable qualifier, buffers entries through a
// two-entry skid buffer and counts committed register writes.
module alu_result_wb_stage
    import cpu_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [4:0]    in_fn_sel,
    input  logic [AW-1:0] in_rd_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [AW-1:0] out_rd_addr,
    output logic [4:0]    out_fn_sel,
    output logic          out_we,
    output logic          out_zero,
    output logic          out_neg,
    output logic          out_parity,
    output logic          out_illegal,
    output logic [CW-1:0] wb_count
);

    wb_entry_t in_entry;
    wb_entry_t out_entry;

    // Capture-time decode: illegal selects write nothing and carry a zero result.
    always_comb begin
        in_entry         = '0;
        in_entry.illegal = fn_is_illegal(in_fn_sel);
        in_entry.data    = in_entry.illegal ? '0 : in_data;
        in_entry.rd_addr = in_rd_addr;
        in_entry.fn_sel  = in_fn_sel;
        in_entry.zero    = (in_entry.data == '0);
        in_entry.neg     = in_entry.data[DATA_W-1];
        in_entry.parity  = ^in_entry.data;
        // Register 0 is hardwired, so a write to it is never committed.
        in_entry.we      = !in_entry.illegal && (in_rd_addr != '0);
    end

    wb_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (out_entry)
    );

    assign out_data    = out_entry.data;
    assign out_rd_addr = out_entry.rd_addr;
    assign out_fn_sel  = out_entry.fn_sel;
    assign out_we      = out_entry.we;
    assign out_zero    = out_entry.zero;
    assign out_neg     = out_entry.neg;
    assign out_parity  = out_entry.parity;
    assign out_illegal = out_entry.illegal;

    // Count committed register writes; wraps naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= '0;
        end else if (out_valid && out_ready && out_we) begin
            wb_count <= wb_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_wb_stage.sv
// Bench for alu_result_wb_stage: a scoreboard queue of expected entries is
// filled at each accept and drained at each output transfer, alongside
// directed checks of flags, backpressure, stream and reset behaviour.
module tb_alu_result_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [4:0]  in_fn_sel;
    logic [3:0]  in_rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_rd_addr;
    logic [4:0]  out_fn_sel;
    logic        out_we;
    logic        out_zero;
    logic        out_neg;
    logic        out_parity;
    logic        out_illegal;
    logic [7:0]  wb_count;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  rd;
        logic [4:0]  fn;
        logic        we;
        logic        zero;
        logic        neg;
        logic        parity;
        logic        illegal;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_cnt;
    int         n_checks;
    int         n_err;

    alu_result_wb_stage #(.N(16), .AW(4), .CW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_fn_sel   (in_fn_sel),
        .in_rd_addr  (in_rd_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd_addr (out_rd_addr),
        .out_fn_sel  (out_fn_sel),
        .out_we      (out_we),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_parity  (out_parity),
        .out_illegal (out_illegal),
        .wb_count    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [15:0] d, input logic [4:0] fn, input logic [3:0] rd);
        exp_t e;
        int   ones;
        e.illegal = (fn > 5'd15);
        e.data    = e.illegal ? 16'h0000 : d;
        ones      = 0;
        for (int k = 0; k < 16; k++) begin
            if (e.data[k]) ones++;
        end
        e.parity = ones[0];
        e.zero   = (e.data == 16'h0000);
        e.neg    = e.data[15];
        e.we     = !e.illegal && (rd != 4'd0);
        e.rd     = rd;
        e.fn     = fn;
        return e;
    endfunction

    // Scoreboard: sampled on the falling edge, where the handshake for the
    // next rising edge is already settled.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("wb_count", wb_count, exp_cnt);
            if (out_valid && out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_data", out_data, e.data);
                    chk("sb_rd", out_rd_addr, e.rd);
                    chk("sb_fn", out_fn_sel, e.fn);
                    chk("sb_we", out_we, e.we);
                    chk("sb_zero", out_zero, e.zero);
                    chk("sb_neg", out_neg, e.neg);
                    chk("sb_parity", out_parity, e.parity);
                    chk("sb_illegal", out_illegal, e.illegal);
                    if (e.we) exp_cnt = exp_cnt + 8'd1;
                end
            end
            if (in_valid && in_ready) sb.push_back(mk_exp(in_data, in_fn_sel, in_rd_addr));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [15:0] d, input logic [4:0] fn, input logic [3:0] rd);
        logic ok;
        int   tries;
        in_valid   = 1'b1;
        in_data    = d;
        in_fn_sel  = fn;
        in_rd_addr = rd;
        tries      = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 50);
        chk("accept_timeout", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] base;
        n_checks   = 0;
        n_err      = 0;
        exp_cnt    = 8'd0;
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = 16'hBEEF;
        in_fn_sel  = 5'd1;
        in_rd_addr = 4'd1;

        // Reset state, with in_valid held high across edges during reset
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_count", wb_count, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_we, out_zero, out_neg, out_parity, out_illegal}, 0);
        #19;
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_no_capture", out_valid, 0);

        // Single pass
        out_ready = 1'b1;
        push(16'h8001, 5'd3, 4'd5);
        chk("sp_valid", out_valid, 1);
        chk("sp_data", out_data, 16'h8001);
        chk("sp_flags", {out_neg, out_zero, out_parity, out_we, out_illegal}, 5'b10010);
        chk("sp_cnt_before", wb_count, 0);
        idle(1);
        chk("sp_cnt_after", wb_count, 1);

        // Backpressure
        out_ready = 1'b0;
        base = wb_count;
        push(16'h0011, 5'd2, 4'd1);
        push(16'h0022, 5'd2, 4'd2);
        chk("bp_in_ready_low", in_ready, 0);
        in_valid   = 1'b1;
        in_data    = 16'h0033;
        in_fn_sel  = 5'd2;
        in_rd_addr = 4'd3;
        idle(2);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_data", out_data, 16'h0011);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_out0", out_data, 16'h0011);
        idle(1);
        chk("bp_out1", out_data, 16'h0022);
        chk("bp_ready_back", in_ready, 1);
        idle(1);
        in_valid = 1'b0;
        chk("bp_out2", out_data, 16'h0033);
        chk("bp_out2_valid", out_valid, 1);
        idle(1);
        chk("bp_drained", out_valid, 0);
        chk("bp_count", wb_count, base + 8'd3);

        // Illegal function select
        base = wb_count;
        push(16'h1234, 5'd17, 4'd2);
        chk("il_data", out_data, 0);
        chk("il_zero", out_zero, 1);
        chk("il_illegal", out_illegal, 1);
        chk("il_we", out_we, 0);
        idle(1);
        chk("il_count", wb_count, base);

        // Register 0 destination
        push(16'h00FF, 5'd1, 4'd0);
        chk("r0_we", out_we, 0);
        chk("r0_parity", out_parity, 0);
        chk("r0_data", out_data, 16'h00FF);
        idle(1);
        chk("r0_count", wb_count, base);

        // Stream without stalls
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'b1;
            in_data    = 16'h0100 + 16'(i);
            in_fn_sel  = 5'(i);
            in_rd_addr = 4'(i + 1);
            @(posedge clk);
            #1;
            chk("st_in_ready", in_ready, 1);
            chk("st_valid", out_valid, 1);
            chk("st_data", out_data, 16'h0100 + 16'(i));
        end
        in_valid = 1'b0;
        idle(1);

        // Counter wrap over a long stream
        base = wb_count;
        for (int i = 0; i < 260; i++) begin
            in_valid   = 1'b1;
            in_data    = 16'($urandom);
            in_fn_sel  = 5'($urandom_range(0, 15));
            in_rd_addr = 4'($urandom_range(1, 15));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        idle(2);
        chk("wrap_count", wb_count, base + 8'd4);

        // Reset mid-operation with both entries full
        out_ready = 1'b0;
        push(16'hAAAA, 5'd4, 4'd6);
        push(16'h5555, 5'd4, 4'd7);
        chk("mr_full", in_ready, 0);
        #2 rst_n = 1'b0;
        sb.delete();
        exp_cnt = 8'd0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_wb_count", wb_count, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_empty", out_valid, 0);
        push(16'h0F0F, 5'd6, 4'd9);
        chk("mr_first_valid", out_valid, 1);
        chk("mr_first_data", out_data, 16'h0F0F);
        out_ready = 1'b1;
        idle(2);
        chk("mr_count", wb_count, 1);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
